// File: rtl/fetch_controller.sv
`timescale 1ns/1ps
// Purpose : IF-stage / pipeline-register sequencer for the 5-stage RISC-V core (boot hold, load-use stall, branch flush, halt/resume) with fetch/stall counters.
// Latency : control strobes are Mealy (same cycle as the causing input); halt -> halted one cycle later; resume -> fetch one cycle later.
// Backpressure: load_use_hazard freezes PC and IF/ID for as long as it is held; HALT freezes fetch until resume_req without halt_req.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   load_use_hazard            ID instruction depends on the load currently in EX
//   branch_taken               EX resolved a taken branch/jump; PC_Branch is valid
//   halt_instr_ID              ID holds an ebreak
//   halt_req / resume_req      external halt level / single-cycle resume pulse
//   PC_write, PCSrc            IF PC enable and next-PC mux select (1 = PC_Branch)
//   IF_ID_write                IF/ID register enable
//   flush_IF_ID, flush_ID_EX   NOP/bubble insertion at the next edge
//   halted                     core is parked in HALT
//   fetch_count                instructions accepted by IF, wraps
//   stall_count                load-use stall cycles, saturates at all-ones
module fetch_controller #(
    parameter int unsigned BOOT_DELAY   = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             halt_instr_ID,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             PC_write,
    output logic             PCSrc,
    output logic             IF_ID_write,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0]       BOOT_INIT   = 8'(BOOT_DELAY);
    localparam logic [3:0]       FL_RELOAD   = 4'(FLUSH_CYCLES - 1);
    localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t     state_q, state_d;
    logic [7:0] boot_cnt_q, boot_cnt_d;
    logic [3:0] fl_cnt_q, fl_cnt_d;
    logic       stall_inc;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BOOT_INIT;
            fl_cnt_q    <= 4'd0;
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            // PC_write is always low in BOOT, so this only counts real fetches.
            if (PC_write) begin
                fetch_count <= fetch_count + CNT_ONE;
            end
            if (stall_inc && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        stall_inc   = 1'b0;
        PC_write    = 1'b0;
        PCSrc       = 1'b0;
        IF_ID_write = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Pipe held empty; every input is ignored. boot_cnt counts
                // the hold cycles still to go including this one, so the
                // core sits here BOOT_DELAY cycles (one cycle minimum when
                // BOOT_DELAY is 0).
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                if (boot_cnt_q <= 8'd1) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = 8'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q - 8'd1;
                end
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect wins over halt: an ebreak in ID is on the
                    // wrong path, and a halt_req is simply seen later.
                    PC_write    = 1'b1;
                    PCSrc       = 1'b1;
                    IF_ID_write = 1'b1;
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d  = ST_FLUSH;
                        fl_cnt_d = FL_RELOAD;
                    end
                end else if (halt_req || halt_instr_ID) begin
                    flush_ID_EX = 1'b1;
                    state_d     = ST_HALT;
                end else if (load_use_hazard) begin
                    flush_ID_EX = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Keep fetching down the new path while the wrong-path
                // slots drain; hazards and halts are not meaningful here.
                PC_write    = 1'b1;
                IF_ID_write = 1'b1;
                PCSrc       = branch_taken;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                if (branch_taken) begin
                    fl_cnt_d = FL_RELOAD;
                end else if (fl_cnt_q <= 4'd1) begin
                    state_d  = ST_RUN;
                    fl_cnt_d = 4'd0;
                end else begin
                    fl_cnt_d = fl_cnt_q - 4'd1;
                end
            end

            ST_HALT: begin
                flush_ID_EX = 1'b1;
                // halted drops in the resume cycle itself so the debugger
                // sees the release without waiting an extra edge.
                if (resume_req && !halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    halted = 1'b1;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
// Purpose : directed self-checking bench for fetch_controller (BOOT_DELAY=4, FLUSH_CYCLES=2, CNT_W=4).
// Latency : inputs driven 1ns after the rising edge, outputs sampled at the falling edge.
// Backpressure: n/a (bench).
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_use_hazard;
    logic       branch_taken;
    logic       halt_instr_ID;
    logic       halt_req;
    logic       resume_req;
    logic       PC_write;
    logic       PCSrc;
    logic       IF_ID_write;
    logic       flush_IF_ID;
    logic       flush_ID_EX;
    logic       halted;
    logic [3:0] fetch_count;
    logic [3:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_controller #(
        .BOOT_DELAY  (4),
        .FLUSH_CYCLES(2),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_use_hazard(load_use_hazard),
        .branch_taken   (branch_taken),
        .halt_instr_ID  (halt_instr_ID),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .PC_write       (PC_write),
        .PCSrc          (PCSrc),
        .IF_ID_write    (IF_ID_write),
        .flush_IF_ID    (flush_IF_ID),
        .flush_ID_EX    (flush_ID_EX),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move from edge+1 to the falling edge for sampling.
    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        load_use_hazard = 1'b0;
        branch_taken    = 1'b0;
        halt_instr_ID   = 1'b0;
        halt_req        = 1'b0;
        resume_req      = 1'b0;
    endtask

    // Reset, release, and walk the 4 boot cycles. Returns at the start of
    // the first RUN cycle with inputs idle. With noise set, hazard/branch/
    // halt inputs are held high through boot and must have no effect.
    task automatic boot(input bit noise);
        reset = 1'b0;
        clear_inputs();
        tick();
        settle();
        chk("rst_pc_write",  32'(PC_write), 0);
        chk("rst_if_id_wr",  32'(IF_ID_write), 0);
        chk("rst_pcsrc",     32'(PCSrc), 0);
        chk("rst_flush_ifid", 32'(flush_IF_ID), 1);
        chk("rst_flush_idex", 32'(flush_ID_EX), 1);
        chk("rst_halted",    32'(halted), 0);
        chk("rst_fetch_cnt", 32'(fetch_count), 0);
        chk("rst_stall_cnt", 32'(stall_count), 0);
        tick();
        reset = 1'b1;
        if (noise) begin
            load_use_hazard = 1'b1;
            branch_taken    = 1'b1;
            halt_instr_ID   = 1'b1;
            halt_req        = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("boot_pc_write", 32'(PC_write), 0);
            chk("boot_flush_ifid", 32'(flush_IF_ID), 1);
            if (noise) begin
                chk("boot_pcsrc", 32'(PCSrc), 0);
                chk("boot_halted", 32'(halted), 0);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();

        // 1: boot hold then first fetch
        boot(1'b0);
        settle();
        chk("t1_first_fetch", 32'(PC_write), 1);
        chk("t1_first_ifid",  32'(IF_ID_write), 1);
        tick();
        chk("t1_fetch_cnt", 32'(fetch_count), 1);

        // 2: two-cycle load-use stall
        load_use_hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t2_stall_pc_write", 32'(PC_write), 0);
            chk("t2_stall_ifid_wr",  32'(IF_ID_write), 0);
            chk("t2_stall_flush_idex", 32'(flush_ID_EX), 1);
            chk("t2_stall_flush_ifid", 32'(flush_IF_ID), 0);
            tick();
        end
        load_use_hazard = 1'b0;
        chk("t2_stall_cnt", 32'(stall_count), 2);
        chk("t2_fetch_cnt", 32'(fetch_count), 1);

        // 3: taken branch with a two-cycle flush
        branch_taken = 1'b1;
        settle();
        chk("t3_br_pcsrc",  32'(PCSrc), 1);
        chk("t3_br_pc_write", 32'(PC_write), 1);
        chk("t3_br_flush_ifid", 32'(flush_IF_ID), 1);
        chk("t3_br_flush_idex", 32'(flush_ID_EX), 1);
        tick();
        branch_taken = 1'b0;
        settle();
        chk("t3_fl_pcsrc", 32'(PCSrc), 0);
        chk("t3_fl_flush_ifid", 32'(flush_IF_ID), 1);
        chk("t3_fl_flush_idex", 32'(flush_ID_EX), 1);
        chk("t3_fl_pc_write", 32'(PC_write), 1);
        tick();
        settle();
        chk("t3_run_flush_ifid", 32'(flush_IF_ID), 0);
        chk("t3_run_flush_idex", 32'(flush_ID_EX), 0);
        chk("t3_run_pc_write", 32'(PC_write), 1);
        tick();
        chk("t3_fetch_cnt", 32'(fetch_count), 4);

        // 4a: branch squashes an ebreak in ID
        branch_taken  = 1'b1;
        halt_instr_ID = 1'b1;
        settle();
        chk("t4a_pcsrc", 32'(PCSrc), 1);
        chk("t4a_halted", 32'(halted), 0);
        tick();
        branch_taken  = 1'b0;
        halt_instr_ID = 1'b0;
        settle();
        chk("t4a_fl_flush_ifid", 32'(flush_IF_ID), 1);
        tick();
        settle();
        chk("t4a_run_pc_write", 32'(PC_write), 1);
        chk("t4a_run_halted", 32'(halted), 0);
        chk("t4a_run_flush_idex", 32'(flush_ID_EX), 0);
        tick();

        // 4b: halt_req held across a branch: HALT after the redirect
        branch_taken = 1'b1;
        halt_req     = 1'b1;
        settle();
        chk("t4b_pcsrc", 32'(PCSrc), 1);
        chk("t4b_pc_write", 32'(PC_write), 1);
        tick();
        branch_taken = 1'b0;
        settle();
        chk("t4b_fl_pc_write", 32'(PC_write), 1);
        chk("t4b_fl_halted", 32'(halted), 0);
        tick();
        settle();
        chk("t4b_hreq_pc_write", 32'(PC_write), 0);
        chk("t4b_hreq_ifid_wr", 32'(IF_ID_write), 0);
        chk("t4b_hreq_flush_idex", 32'(flush_ID_EX), 1);
        chk("t4b_hreq_halted", 32'(halted), 0);
        tick();
        halt_req = 1'b0;
        settle();
        chk("t4b_halted", 32'(halted), 1);

        // 5: HALT behaviour, resume, and a single halt_req pulse
        branch_taken = 1'b1;
        settle();
        chk("t5_halt_br_pcsrc", 32'(PCSrc), 0);
        chk("t5_halt_br_pc_write", 32'(PC_write), 0);
        tick();
        branch_taken = 1'b0;
        halt_req     = 1'b1;
        resume_req   = 1'b1;
        settle();
        chk("t5_resume_blocked", 32'(halted), 1);
        tick();
        halt_req = 1'b0;
        settle();
        chk("t5_resume_halted", 32'(halted), 0);
        chk("t5_resume_pc_write", 32'(PC_write), 0);
        tick();
        resume_req = 1'b0;
        settle();
        chk("t5_run_pc_write", 32'(PC_write), 1);
        chk("t5_run_halted", 32'(halted), 0);
        tick();
        halt_req = 1'b1;
        settle();
        chk("t5_pulse_pc_write", 32'(PC_write), 0);
        chk("t5_pulse_halted", 32'(halted), 0);
        tick();
        halt_req = 1'b0;
        settle();
        chk("t5_pulse_halted_next", 32'(halted), 1);
        chk("t5_halt_flush_ifid", 32'(flush_IF_ID), 0);
        chk("t5_halt_flush_idex", 32'(flush_ID_EX), 1);
        tick();
        chk("t5_fetch_cnt", 32'(fetch_count), 10);
        chk("t5_stall_cnt", 32'(stall_count), 2);

        // 6: counter saturation/wrap at 4 bits, then reset mid-HALT
        boot(1'b1);
        chk("t6_boot_stall_cnt", 32'(stall_count), 0);
        chk("t6_boot_fetch_cnt", 32'(fetch_count), 0);
        load_use_hazard = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        load_use_hazard = 1'b0;
        chk("t6_stall_sat", 32'(stall_count), 15);
        chk("t6_fetch_none", 32'(fetch_count), 0);
        for (int i = 0; i < 17; i++) tick();
        chk("t6_fetch_wrap", 32'(fetch_count), 1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        settle();
        chk("t6_halted", 32'(halted), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_halted", 32'(halted), 0);
        chk("t6_rst_fetch_cnt", 32'(fetch_count), 0);
        chk("t6_rst_stall_cnt", 32'(stall_count), 0);
        chk("t6_rst_pc_write", 32'(PC_write), 0);
        chk("t6_rst_flush_ifid", 32'(flush_IF_ID), 1);
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("t6_reboot_pc_write", 32'(PC_write), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
